// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants (byte width, receive FIFO depth) and sizing helpers
// used by the receive FIFO, its interface and the storage array.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: byte/status from the receiver, pop/clear from the consumer,
// and the FIFO head and status flags back to the consumer.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_FIFO_DEPTH
);
    logic [DATA_WIDTH-1:0]       rx_data;
    logic                        rx_status;
    logic                        rd_en;
    logic                        ovf_clr;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic                        empty;
    logic                        full;
    logic [cnt_width(DEPTH)-1:0] count;
    logic                        overflow;

    modport master (
        output rx_data, rx_status, rd_en, ovf_clr,
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_status, rd_en, ovf_clr,
        output rd_data, empty, full, count, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: one synchronous write port, one asynchronous read port,
// no reset (contents are only meaningful behind the owner's count).
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: turns each rising edge of the receiver status into one
// push, holds bytes first-word fall-through, and flags dropped bytes.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          rx_status_buf_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          overflow_next;

    logic                  push;
    logic                  pop;
    logic                  do_write;
    logic                  drop;
    logic                  empty_w;
    logic                  full_w;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty_w  = (count_reg == '0);
    assign full_w   = (count_reg == DEPTH_C);
    assign push     = ~rx_status_buf_reg & bus.rx_status;
    assign pop      = bus.rd_en & ~empty_w;
    // When full, a simultaneous pop frees the head slot, which is the write slot.
    assign do_write = push & (~full_w | pop);
    assign drop     = push & full_w & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({do_write, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    // Status buffer resets high so an idle-high receiver line is not a push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_status_buf_reg <= 1'b1;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            overflow_reg      <= 1'b0;
        end else begin
            rx_status_buf_reg <= bus.rx_status;
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr_reg),
        .wdata (bus.rx_data),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    assign bus.rd_data  = empty_w ? '0 : mem_rdata;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width from the receiver.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock (16x baud clock from clkdiv); all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  DATA_WIDTH  received byte from the receiver; valid when rx_status rises.
REQ-006 SHALL have port rx_status  input  1  receiver status; a 0->1 transition marks one completed byte.
REQ-007 SHALL have port rd_en  input  1  consumer pop request, single-cycle pulse or level.
REQ-008 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-009 SHALL have port rd_data  output  DATA_WIDTH  head entry (first-word fall-through); 0 when empty.
REQ-010 SHALL have port empty  output  1  no entries stored.
REQ-011 SHALL have port full  output  1  DEPTH entries stored.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  entries stored, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-014 SHALL register rx_status into rx_status_buf every cycle; push = (~rx_status_buf & rx_status), evaluated on the same edge that sampled the 1.
REQ-015 SHALL write rx_data at wr_ptr on push when not full; wr_ptr increments mod DEPTH.
REQ-016 SHALL present mem[rd_ptr] on rd_data combinationally whenever empty=0; latency from push to visible head is 1 cycle.
REQ-017 SHALL advance rd_ptr mod DEPTH on rd_en when empty=0; rd_en while empty is ignored (no pointer, count or flag change).
REQ-018 SHALL, on push and pop in the same cycle with 0<count<DEPTH, perform both; count unchanged.
REQ-019 SHALL, on push and pop in the same cycle when full, perform both (the pop frees the slot); count stays DEPTH; overflow not set.
REQ-020 SHALL, on push and pop in the same cycle when empty, accept the push only; count becomes 1.
REQ-021 SHALL, on push when full without pop, drop the byte, leave memory and pointers unchanged, and set overflow.
REQ-022 SHALL clear overflow on ovf_clr; a dropped byte in the same cycle wins (overflow stays 1).
REQ-023 SHALL derive empty = (count==0) and full = (count==DEPTH) from the registered count, not from pointer comparison alone.
REQ-024 SHALL hold a level rx_status=1 as a single push; a new push requires a 1->0->1 sequence.

Reset
REQ-025 SHALL, on reset low, asynchronously clear wr_ptr, rd_ptr, count and overflow, and set rx_status_buf to 1 so that rx_status idle-high after reset causes no push.
REQ-026 SHALL discard all stored data on reset, including mid-stream; memory contents need no reset; rd_data reads 0 since empty=1.
REQ-027 SHALL resume normal operation on the first clk edge after reset deasserts.

Structure
REQ-028 SHALL take DATA_WIDTH and FIFO_DEPTH defaults from the shared uart_defs constants file, shared with uart, uarttx and uartrx.
REQ-029 SHALL place the storage array in one sub-module, uart_fifo_mem (one write port, one asynchronous read port, no reset); pointers, count, flags and edge detect stay in uart_rx_fifo.

Verification
REQ-030 SHALL verify single byte: after reset, rx_data=8'hA5 with a rx_status 0->1 edge -> next cycle empty=0, count=1, rd_data=8'hA5; after one rd_en cycle empty=1, rd_data=0.
REQ-031 SHALL verify order and wrap: push 0x01..0x10 (16 edges) -> full=1, count=16; pop all -> 0x01..0x10 in order; then push 0x11 and pop -> 0x11 (pointer wrap).
REQ-032 SHALL verify overflow: when full, push 0xEE -> count=16, overflow=1, head still 0x01; ovf_clr pulse -> overflow=0; overflow event plus ovf_clr in the same cycle -> overflow=1.
REQ-033 SHALL verify simultaneous events: count=5 with push+pop -> count=5; full with push+pop -> count=16, overflow=0, new byte last out; empty with push+pop -> count=1.
REQ-034 SHALL verify edge handling: rx_status high across reset release -> no push; rx_status held high 10 cycles -> exactly one push; rd_en while empty -> count=0, no flag change.
REQ-035 SHALL verify reset mid-operation: with count=7, assert reset between clk edges -> count=0, empty=1, overflow=0 immediately, without waiting for a clk edge.
